// File: rtl/regfile_scb.sv
// Two-read / two-write register file with a per-register busy scoreboard for RAW stalls.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] waddr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] waddr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              scb_full
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH - ((ZERO_REG != 0) ? 1 : 0));

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    logic wr_a_ok, wr_b_ok, issue_ok;
    logic cnt_inc, cnt_dec;

    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign wr_a_ok  = we_a && is_writable(waddr_a);
    assign wr_b_ok  = we_b && is_writable(waddr_b);
    assign issue_ok = issue_valid && is_writable(issue_addr);

    // Register array; port B is applied first so port A wins on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_b_ok) mem_q[waddr_b] <= wdata_b;
            if (wr_a_ok) mem_q[waddr_a] <= wdata_a;
        end
    end

    // Scoreboard next state: a new issue supersedes a retiring write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (we_b) busy_d[waddr_b] = 1'b0;
        if (issue_ok) busy_d[issue_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_inc = issue_ok && !busy_q[issue_addr];
        cnt_dec = we_b && busy_q[waddr_b] && !(issue_ok && (issue_addr == waddr_b));
        busy_cnt_d = busy_cnt_q;
        if (cnt_inc && !cnt_dec) begin
            busy_cnt_d = busy_cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    function automatic logic [DATA_W-1:0] fwd_data(input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] d;
        d = mem_q[raddr];
        if (!reset && is_writable(raddr)) begin
            if (we_a && (waddr_a == raddr)) begin
                d = wdata_a;
            end else if (we_b && (waddr_b == raddr)) begin
                d = wdata_b;
            end
        end
        return d;
    endfunction

    function automatic logic fwd_busy(input logic [ADDR_W-1:0] raddr);
        logic b;
        b = busy_q[raddr];
        if (!reset && we_b && (waddr_b == raddr) && !(issue_valid && (issue_addr == raddr))) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        rdata1 = fwd_data(raddr1);
        rdata2 = fwd_data(raddr2);
        busy1  = fwd_busy(raddr1);
        busy2  = fwd_busy(raddr2);
        if (!is_writable(raddr1)) rdata1 = '0;
        if (!is_writable(raddr2)) rdata2 = '0;
    end
`else
    always_comb begin
        rdata1 = is_writable(raddr1) ? mem_q[raddr1] : '0;
        rdata2 = is_writable(raddr2) ? mem_q[raddr2] : '0;
        busy1  = busy_q[raddr1];
        busy2  = busy_q[raddr2];
    end
`endif

    assign busy_cnt = busy_cnt_q;
    assign scb_full = (busy_cnt_q == FULL_CNT);

endmodule
